// File: rtl/gps_clock_pkg.sv
// Shared GPS clock types: sync states, BCD time-of-day layout and digit limits.
// Reused by the UART capture, time keeper and display blocks.
package gps_clock_pkg;

  typedef enum logic [1:0] {
    ACQUIRE  = 2'd0,
    ARMED    = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } sync_state_e;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX  = 3'd5;
  localparam int         HOUR_MAX  = 23;

  typedef struct packed {
    logic [1:0] hour_2;
    logic [3:0] hour_1;
    logic [2:0] min_2;
    logic [3:0] min_1;
    logic [2:0] sec_2;
    logic [3:0] sec_1;
  } bcd_time_t;

  localparam int BCD_TIME_W = $bits(bcd_time_t);

  function automatic logic bcd_time_ok(bcd_time_t t);
    return (t.sec_1 <= UNITS_MAX) && (t.sec_2 <= TENS_MAX) &&
           (t.min_1 <= UNITS_MAX) && (t.min_2 <= TENS_MAX) &&
           (t.hour_1 <= UNITS_MAX) &&
           ((int'(t.hour_2) * 10 + int'(t.hour_1)) <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/bcd_time_inc.sv
// Adds one second to a BCD hh:mm:ss value, wrapping 23:59:59 to 00:00:00.
module bcd_time_inc
  import gps_clock_pkg::*;
(
  input  logic [BCD_TIME_W-1:0] time_i,
  output logic [BCD_TIME_W-1:0] time_o
);

  localparam logic [1:0] LAST_H2 = 2'(HOUR_MAX / 10);
  localparam logic [3:0] LAST_H1 = 4'(HOUR_MAX % 10);

  bcd_time_t cur, nxt;

  assign cur    = time_i;
  assign time_o = nxt;

  always_comb begin
    nxt = cur;
    if (cur.sec_1 != UNITS_MAX) nxt.sec_1 = cur.sec_1 + 4'd1;
    else begin
      nxt.sec_1 = '0;
      if (cur.sec_2 != TENS_MAX) nxt.sec_2 = cur.sec_2 + 3'd1;
      else begin
        nxt.sec_2 = '0;
        if (cur.min_1 != UNITS_MAX) nxt.min_1 = cur.min_1 + 4'd1;
        else begin
          nxt.min_1 = '0;
          if (cur.min_2 != TENS_MAX) nxt.min_2 = cur.min_2 + 3'd1;
          else begin
            nxt.min_2 = '0;
            if (cur.hour_2 == LAST_H2 && cur.hour_1 == LAST_H1) begin
              nxt.hour_2 = '0;
              nxt.hour_1 = '0;
            end else if (cur.hour_1 == UNITS_MAX) begin
              nxt.hour_1 = '0;
              nxt.hour_2 = cur.hour_2 + 2'd1;
            end else begin
              nxt.hour_1 = cur.hour_1 + 4'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/gps_time_keeper.sv
// Stages validated GPS time, loads it on 1PPS, keeps time on PPS and
// free-runs on an internal holdover tick when PPS disappears.
module gps_time_keeper
  import gps_clock_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int PPS_MARGIN     = 5_000_000,
  parameter int HOLDOVER_MAX_S = 600,
  parameter int MISMATCH_LIMIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pps_single_clk,
  input  logic       gps_update,
  input  logic [3:0] gps_sec_1,
  input  logic [2:0] gps_sec_2,
  input  logic [3:0] gps_min_1,
  input  logic [2:0] gps_min_2,
  input  logic [3:0] gps_hour_1,
  input  logic [1:0] gps_hour_2,
  output logic [3:0] sec_1,
  output logic [2:0] sec_2,
  output logic [3:0] min_1,
  output logic [2:0] min_2,
  output logic [3:0] hour_1,
  output logic [1:0] hour_2,
  output logic       sec_tick,
  output logic [1:0] sync_state,
  output logic       time_valid
);

  localparam int LIM = CLK_HZ + PPS_MARGIN;
  localparam int CW  = $clog2(LIM + 1);
  localparam int HW  = $clog2(HOLDOVER_MAX_S + 1);
  localparam int MW  = $clog2(MISMATCH_LIMIT + 1);

  sync_state_e   state_q;
  bcd_time_t     time_q, staged_q, gps_t, inc_in, inc_out;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [HW-1:0] hold_s_q;
  logic [MW-1:0] mis_q, mis_d;
  logic          tick_q, valid_q, upd_ok, cyc_lim;

  assign gps_t  = '{hour_2: gps_hour_2, hour_1: gps_hour_1, min_2: gps_min_2,
                    min_1: gps_min_1, sec_2: gps_sec_2, sec_1: gps_sec_1};
  assign upd_ok = gps_update && bcd_time_ok(gps_t);

  // The ARMED load is staged+1s, every other increment advances the running time.
  assign inc_in = (state_q == ARMED) ? staged_q : time_q;

  bcd_time_inc u_inc (
    .time_i (inc_in),
    .time_o (inc_out)
  );

  assign cyc_lim = (cyc_q == CW'(LIM));
  assign cyc_d   = pps_single_clk ? '0 : (cyc_lim ? cyc_q : cyc_q + 1'b1);
  assign mis_d   = mis_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ACQUIRE;
      time_q   <= '0;
      staged_q <= '0;
      cyc_q    <= '0;
      hold_s_q <= '0;
      mis_q    <= '0;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      cyc_q  <= cyc_d;
      case (state_q)
        ACQUIRE: begin
          if (!pps_single_clk && upd_ok) begin
            staged_q <= gps_t;
            state_q  <= ARMED;
          end
        end
        ARMED: begin
          if (pps_single_clk) begin
            time_q  <= inc_out;
            tick_q  <= 1'b1;
            mis_q   <= '0;
            valid_q <= 1'b1;
            state_q <= LOCKED;
          end else if (cyc_lim) begin
            state_q <= ACQUIRE;
          end else if (upd_ok) begin
            staged_q <= gps_t;
          end
        end
        LOCKED: begin
          if (pps_single_clk) begin
            time_q <= inc_out;
            tick_q <= 1'b1;
          end else if (cyc_lim) begin
            // PPS overdue: credit the missed second and phase the tick to it.
            time_q   <= inc_out;
            tick_q   <= 1'b1;
            cyc_q    <= CW'(PPS_MARGIN);
            hold_s_q <= '0;
            state_q  <= HOLDOVER;
          end else if (upd_ok) begin
            if (gps_t == time_q) mis_q <= '0;
            else begin
              mis_q <= mis_d;
              if (mis_d == MW'(MISMATCH_LIMIT)) begin
                staged_q <= gps_t;
                valid_q  <= 1'b0;
                state_q  <= ARMED;
              end
            end
          end
        end
        HOLDOVER: begin
          if (pps_single_clk) begin
            // An early PPS marks a second the internal tick already counted.
            if (cyc_q >= CW'(CLK_HZ / 2)) begin
              time_q <= inc_out;
              tick_q <= 1'b1;
            end
            state_q <= LOCKED;
          end else if (hold_s_q == HW'(HOLDOVER_MAX_S)) begin
            hold_s_q <= '0;
            valid_q  <= 1'b0;
            state_q  <= ACQUIRE;
          end else if (cyc_q == CW'(CLK_HZ - 1)) begin
            time_q   <= inc_out;
            tick_q   <= 1'b1;
            cyc_q    <= '0;
            hold_s_q <= hold_s_q + 1'b1;
          end
        end
        default: state_q <= ACQUIRE;
      endcase
    end
  end

  assign sec_1      = time_q.sec_1;
  assign sec_2      = time_q.sec_2;
  assign min_1      = time_q.min_1;
  assign min_2      = time_q.min_2;
  assign hour_1     = time_q.hour_1;
  assign hour_2     = time_q.hour_2;
  assign sec_tick   = tick_q;
  assign sync_state = state_q;
  assign time_valid = valid_q;

endmodule

// File: tb/tb_gps_time_keeper.sv
// Bench for gps_time_keeper: directed scenarios plus random PPS/update traffic,
// checked against a seconds-of-day reference model.
module tb_gps_time_keeper;

  localparam int CLK_HZ = 100, PPS_MARGIN = 10, HMAX = 3, MLIM = 2;
  localparam int LIM = CLK_HZ + PPS_MARGIN;
  localparam int DAY = 86400;

  logic clk = 1'b0, reset = 1'b0, pps = 1'b0, upd = 1'b0;
  logic [3:0] gs1 = '0, gm1 = '0, gh1 = '0;
  logic [2:0] gs2 = '0, gm2 = '0;
  logic [1:0] gh2 = '0;
  logic [3:0] sec_1, min_1, hour_1;
  logic [2:0] sec_2, min_2;
  logic [1:0] hour_2, sync_state;
  logic       sec_tick, time_valid;
  logic [23:0] obs;
  logic [19:0] dig;

  int n_cmp = 0, n_bad = 0;

  // Reference model: time kept as seconds since midnight.
  int m_state, m_secs, m_staged, m_cyc, m_mcnt, m_hs;
  bit m_tick;

  gps_time_keeper #(.CLK_HZ(CLK_HZ), .PPS_MARGIN(PPS_MARGIN),
                    .HOLDOVER_MAX_S(HMAX), .MISMATCH_LIMIT(MLIM)) dut (
    .clk(clk), .reset(reset), .pps_single_clk(pps), .gps_update(upd),
    .gps_sec_1(gs1), .gps_sec_2(gs2), .gps_min_1(gm1), .gps_min_2(gm2),
    .gps_hour_1(gh1), .gps_hour_2(gh2),
    .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
    .hour_1(hour_1), .hour_2(hour_2), .sec_tick(sec_tick),
    .sync_state(sync_state), .time_valid(time_valid)
  );

  always #5 clk = ~clk;

  assign dig = {hour_2, hour_1, min_2, min_1, sec_2, sec_1};
  assign obs = {dig, sec_tick, sync_state, time_valid};

  function automatic logic [19:0] digits_of(int secs);
    int t, h, mi, s;
    t = ((secs % DAY) + DAY) % DAY;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    return {2'(h / 10), 4'(h % 10), 3'(mi / 10), 4'(mi % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] exp_vec();
    return {digits_of(m_secs), m_tick, 2'(m_state), (m_state >= 2)};
  endfunction

  function automatic bit gps_ok();
    return int'(gs1) <= 9 && int'(gs2) <= 5 && int'(gm1) <= 9 && int'(gm2) <= 5 &&
           int'(gh1) <= 9 && (int'(gh2) * 10 + int'(gh1)) <= 23;
  endfunction

  function automatic int gps_secs();
    return (int'(gh2) * 10 + int'(gh1)) * 3600 + (int'(gm2) * 10 + int'(gm1)) * 60 +
           int'(gs2) * 10 + int'(gs1);
  endfunction

  task automatic set_gps(input int secs);
    {gh2, gh1, gm2, gm1, gs2, gs1} = digits_of(secs);
  endtask

  task automatic model_reset();
    m_state = 0; m_secs = 0; m_staged = 0; m_cyc = 0; m_mcnt = 0; m_hs = 0; m_tick = 0;
  endtask

  task automatic model_update(input bit p, input bit u);
    bit ok;
    int g, nc;
    ok = u && gps_ok();
    g  = gps_secs();
    nc = p ? 0 : (m_cyc == LIM ? LIM : m_cyc + 1);
    m_tick = 0;
    case (m_state)
      0: if (!p && ok) begin m_staged = g; m_state = 1; end
      1: if (p) begin
           m_secs = (m_staged + 1) % DAY; m_tick = 1; m_mcnt = 0; m_state = 2;
         end else if (m_cyc == LIM) m_state = 0;
         else if (ok) m_staged = g;
      2: if (p) begin m_secs = (m_secs + 1) % DAY; m_tick = 1; end
         else if (m_cyc == LIM) begin
           m_secs = (m_secs + 1) % DAY; m_tick = 1; nc = PPS_MARGIN; m_hs = 0; m_state = 3;
         end else if (ok) begin
           if (g == m_secs) m_mcnt = 0;
           else begin
             m_mcnt++;
             if (m_mcnt >= MLIM) begin m_staged = g; m_state = 1; end
           end
         end
      default: if (p) begin
           if (m_cyc >= CLK_HZ / 2) begin m_secs = (m_secs + 1) % DAY; m_tick = 1; end
           m_state = 2;
         end else if (m_hs == HMAX) m_state = 0;
         else if (m_cyc == CLK_HZ - 1) begin
           m_secs = (m_secs + 1) % DAY; m_tick = 1; nc = 0; m_hs++;
         end
    endcase
    m_cyc = nc;
  endtask

  task automatic step(input bit p, input bit u);
    pps = p; upd = u;
    @(posedge clk);
    model_update(p, u);
    #1;
    pps = 1'b0; upd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    model_reset();
    n_cmp++;
    if (obs !== 24'h0) begin n_bad++; $display("FAIL reset: got %h want %h", obs, 24'h0); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_lock();
    set_gps(12 * 3600 + 34 * 60 + 56);
    repeat (4) step(0, 0);
    step(0, 1);
    n_cmp++;
    if (sync_state !== 2'd1) begin n_bad++; $display("FAIL lock_armed: got %0d want 1", sync_state); end
    for (int i = 6; i < 20; i++) begin
      step(0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL lock_wait %0d: got %h want %h", i, obs, exp_vec()); end
    end
    step(1, 0);
    n_cmp++;
    if (obs !== {2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd7, 1'b1, 2'd2, 1'b1}) begin
      n_bad++; $display("FAIL lock_load: got %h want 12:34:57 tick LOCKED valid", obs);
    end
    step(0, 0);
    n_cmp++;
    if (obs !== exp_vec()) begin n_bad++; $display("FAIL lock_after: got %h want %h", obs, exp_vec()); end
  endtask

  task automatic relock(input int secs);
    set_gps(secs);
    step(0, 1);
    step(0, 1);
    n_cmp++;
    if (obs !== exp_vec() || sync_state !== 2'd1) begin
      n_bad++; $display("FAIL relock_armed: got %h want %h", obs, exp_vec());
    end
    repeat (3) step(0, 0);
    step(1, 0);
    n_cmp++;
    if (dig !== digits_of(secs + 1) || sync_state !== 2'd2) begin
      n_bad++; $display("FAIL relock_load: got %h want %h", dig, digits_of(secs + 1));
    end
  endtask

  task automatic test_wrap();
    relock(23 * 3600 + 59 * 60 + 58);
    repeat (5) step(0, 0);
    step(1, 0);
    n_cmp++;
    if (dig !== 20'h0 || sec_tick !== 1'b1) begin
      n_bad++; $display("FAIL wrap_midnight: got %h tick %b want 00:00:00 tick", dig, sec_tick);
    end
    relock(9 * 3600 + 59 * 60 + 58);
    step(1, 0);
    n_cmp++;
    if (dig !== {2'd1, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0}) begin
      n_bad++; $display("FAIL wrap_ten: got %h want 10:00:00", dig);
    end
  endtask

  task automatic run_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(0, 0);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL %s %0d: got %h want %h", tag, i, obs, exp_vec()); end
    end
  endtask

  task automatic test_holdover();
    int s0;
    s0 = m_secs;
    run_quiet(111, "hold_entry");
    n_cmp++;
    if (sync_state !== 2'd3 || dig !== digits_of(s0 + 1) || sec_tick !== 1'b1) begin
      n_bad++; $display("FAIL hold_enter: got %h st %0d want %h st 3", dig, sync_state, digits_of(s0 + 1));
    end
    run_quiet(90, "hold_tick");
    n_cmp++;
    if (dig !== digits_of(s0 + 2) || sec_tick !== 1'b1) begin
      n_bad++; $display("FAIL hold_tick: got %h want %h", dig, digits_of(s0 + 2));
    end
    for (int i = 0; i < 100 && m_cyc != 60; i++) step(0, 0);
    n_cmp++;
    if (m_cyc != 60) begin n_bad++; $display("FAIL hold_wait: cyc %0d want 60", m_cyc); end
    step(1, 0);
    n_cmp++;
    if (dig !== digits_of(s0 + 3) || sync_state !== 2'd2 || sec_tick !== 1'b1) begin
      n_bad++; $display("FAIL hold_late_pps: got %h st %0d want %h st 2", dig, sync_state, digits_of(s0 + 3));
    end
    s0 = m_secs;
    run_quiet(111 + 90 + 20, "hold_early");
    step(1, 0);
    n_cmp++;
    if (dig !== digits_of(s0 + 2) || sync_state !== 2'd2 || sec_tick !== 1'b0) begin
      n_bad++; $display("FAIL hold_early_pps: got %h st %0d want %h st 2", dig, sync_state, digits_of(s0 + 2));
    end
    s0 = m_secs;
    run_quiet(111 + 89, "hold_coinc");
    step(1, 0);
    n_cmp++;
    if (dig !== digits_of(s0 + 2) || sync_state !== 2'd2) begin
      n_bad++; $display("FAIL hold_coinc_pps: got %h st %0d want %h st 2", dig, sync_state, digits_of(s0 + 2));
    end
  endtask

  task automatic test_expire();
    int s0;
    s0 = m_secs;
    run_quiet(402, "expire");
    n_cmp++;
    if (sync_state !== 2'd0 || time_valid !== 1'b0 || dig !== digits_of(s0 + 4)) begin
      n_bad++; $display("FAIL expire: got %h st %0d v %b want %h st 0 v 0", dig, sync_state, time_valid, digits_of(s0 + 4));
    end
    run_quiet(30, "frozen");
    n_cmp++;
    if (dig !== digits_of(s0 + 4)) begin n_bad++; $display("FAIL frozen: got %h want %h", dig, digits_of(s0 + 4)); end
  endtask

  task automatic test_rearm();
    step(1, 0);
    set_gps(59 * 60 + 59);
    step(0, 1);
    repeat (5) step(0, 0);
    step(1, 0);
    n_cmp++;
    if (dig !== {2'd0, 4'd1, 3'd0, 4'd0, 3'd0, 4'd0} || sync_state !== 2'd2) begin
      n_bad++; $display("FAIL rearm_lock: got %h st %0d want 01:00:00 st 2", dig, sync_state);
    end
    repeat (3) step(0, 0);
    set_gps(5 * 3600);
    step(0, 1);
    n_cmp++;
    if (sync_state !== 2'd2) begin n_bad++; $display("FAIL rearm_first: got st %0d want 2", sync_state); end
    step(0, 1);
    n_cmp++;
    if (sync_state !== 2'd1 || dig !== {2'd0, 4'd1, 3'd0, 4'd0, 3'd0, 4'd0}) begin
      n_bad++; $display("FAIL rearm_second: got %h st %0d want 01:00:00 st 1", dig, sync_state);
    end
    run_quiet(4, "rearm_wait");
    step(1, 0);
    n_cmp++;
    if (dig !== {2'd0, 4'd5, 3'd0, 4'd0, 3'd0, 4'd1} || sync_state !== 2'd2) begin
      n_bad++; $display("FAIL rearm_load: got %h st %0d want 05:00:01 st 2", dig, sync_state);
    end
  endtask

  task automatic test_invalid();
    test_reset();
    {gh2, gh1, gm2, gm1, gs2, gs1} = {2'd1, 4'd2, 3'd6, 4'd0, 3'd0, 4'd0};
    step(0, 1);
    n_cmp++;
    if (sync_state !== 2'd0) begin n_bad++; $display("FAIL bad_min: got st %0d want 0", sync_state); end
    {gh2, gh1, gm2, gm1, gs2, gs1} = {2'd2, 4'd4, 3'd0, 4'd0, 3'd0, 4'd0};
    step(0, 1);
    n_cmp++;
    if (sync_state !== 2'd0) begin n_bad++; $display("FAIL bad_hour: got st %0d want 0", sync_state); end
    set_gps(8 * 3600);
    step(0, 1);
    run_quiet(3, "inv_arm");
    step(1, 0);
    set_gps(11 * 3600 + 11 * 60 + 11);
    step(0, 1);
    step(1, 1);
    n_cmp++;
    if (sync_state !== 2'd2 || dig !== {2'd0, 4'd8, 3'd0, 4'd0, 3'd0, 4'd2}) begin
      n_bad++; $display("FAIL coinc_update: got %h st %0d want 08:00:02 st 2", dig, sync_state);
    end
    {gh2, gh1, gm2, gm1, gs2, gs1} = {2'd0, 4'd1, 3'd7, 4'd0, 3'd0, 4'd0};
    step(0, 1);
    n_cmp++;
    if (sync_state !== 2'd2) begin n_bad++; $display("FAIL locked_bad: got st %0d want 2", sync_state); end
    set_gps(11 * 3600 + 11 * 60 + 11);
    step(0, 1);
    n_cmp++;
    if (sync_state !== 2'd1 || obs !== exp_vec()) begin
      n_bad++; $display("FAIL mis_kept: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    step(1, 0);
    run_quiet(7, "pre_reset");
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (obs !== 24'h0) begin n_bad++; $display("FAIL reset_mid: got %h want %h", obs, 24'h0); end
    @(negedge clk) reset = 1'b1;
    run_quiet(3, "post_reset");
  endtask

  task automatic test_random();
    int next_pps;
    next_pps = $urandom_range(60, 120);
    for (int i = 0; i < 4000; i++) begin
      bit p, u;
      p = (next_pps == 0);
      if (p) next_pps = ($urandom_range(0, 9) == 0) ? $urandom_range(150, 500) : $urandom_range(40, 125);
      else next_pps--;
      u = ($urandom_range(0, 5) == 0);
      if (u) begin
        case ($urandom_range(0, 3))
          0: set_gps(m_secs);
          1: set_gps(m_secs + $urandom_range(1, 3));
          2: set_gps($urandom_range(0, DAY - 1));
          default: begin
            gs1 = 4'($urandom_range(0, 15)); gs2 = 3'($urandom_range(0, 7));
            gm1 = 4'($urandom_range(0, 15)); gm2 = 3'($urandom_range(0, 7));
            gh1 = 4'($urandom_range(0, 15)); gh2 = 2'($urandom_range(0, 3));
          end
        endcase
      end
      step(p, u);
      n_cmp++;
      if (obs !== exp_vec()) begin n_bad++; $display("FAIL random %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_holdover();
    test_expire();
    test_rearm();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gps_time_keeper.md
Name: gps_time_keeper

Overview:
Sequences the GPS time datapath. It validates decoded GPS time updates, stages them and loads them into the running display time on the next 1PPS edge. It then keeps time on PPS, falls back to an internal holdover tick when PPS is lost, and re-acquires on persistent mismatch. It sits between the GPS UART time-capture block and the display drivers.

Parameters:
CLK_HZ, 50_000_000, clk cycles per nominal second
PPS_MARGIN, 5_000_000, extra cycles beyond CLK_HZ tolerated before PPS is declared lost
HOLDOVER_MAX_S, 600, holdover seconds before time is declared invalid
MISMATCH_LIMIT, 2, consecutive mismatching GPS updates that force re-arm

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pps_single_clk  in  1  one-cycle PPS pulse
gps_update  in  1  one-cycle pulse: gps_* digits are newly captured
gps_sec_1  in  4  GPS seconds units
gps_sec_2  in  3  GPS seconds tens
gps_min_1  in  4  GPS minutes units
gps_min_2  in  3  GPS minutes tens
gps_hour_1  in  4  GPS hours units
gps_hour_2  in  2  GPS hours tens
sec_1, sec_2, min_1, min_2, hour_1, hour_2  out  4,3,4,3,4,2  running time, BCD digits
sec_tick  out  1  one-cycle pulse on every applied second increment or load
sync_state  out  2  0 ACQUIRE, 1 ARMED, 2 LOCKED, 3 HOLDOVER
time_valid  out  1  high in LOCKED/HOLDOVER

Behaviour:
- Reset (async, active-low): all time digits 0; state ACQUIRE; sec_tick 0; time_valid 0; cyc_cnt 0; mismatch_cnt 0; holdover_s 0; staged time 00:00:00.
- All outputs are registered. Digit/state changes appear the cycle after the triggering pulse.
- Valid update:
  - gps_update high, and digits in range: sec_1,min_1,hour_1 ≤9; sec_2,min_2 ≤5; hour ≤23.
  - Out-of-range updates are ignored in every state and leave mismatch_cnt unchanged.
- cyc_cnt:
  - Cleared on every applied PPS.
  - Otherwise increments, saturating at CLK_HZ+PPS_MARGIN.
  - Width is clog2(CLK_HZ+PPS_MARGIN+1).
- Increment: BCD carry chain sec_1 9→0 → sec_2 5→0 → min_1 → min_2 → hour. Hours wrap 23:59:59 → 00:00:00. Hour_1 wraps 9→0 into hour_2 below 20.
- ACQUIRE: time digits hold. A valid update loads staged time → ARMED.
- ARMED:
  - A later valid update overwrites staged time.
  - PPS loads staged+1s into the digits, pulses sec_tick, clears cyc_cnt and mismatch_cnt → LOCKED.
  - If cyc_cnt reaches CLK_HZ+PPS_MARGIN with no PPS → ACQUIRE.
- LOCKED:
  - PPS: increment, sec_tick, cyc_cnt=0.
  - Valid update is compared with the current digits. Equal → mismatch_cnt=0. Unequal → mismatch_cnt+1.
  - When mismatch_cnt reaches MISMATCH_LIMIT: staged ← gps digits → ARMED. Digits hold until the ARMED PPS load.
  - cyc_cnt reaching CLK_HZ+PPS_MARGIN: increment (the missed second), sec_tick, cyc_cnt ← PPS_MARGIN, holdover_s=0 → HOLDOVER.
- HOLDOVER:
  - cyc_cnt == CLK_HZ−1: increment, sec_tick, cyc_cnt=0, holdover_s+1.
  - PPS with cyc_cnt ≥ CLK_HZ/2: increment, sec_tick. PPS with cyc_cnt < CLK_HZ/2: no increment (the internal tick already counted this second). Either case: cyc_cnt=0 → LOCKED.
  - holdover_s == HOLDOVER_MAX_S → ACQUIRE, time_valid=0, digits hold.
  - GPS updates are ignored.
- Simultaneous PPS and gps_update:
  - PPS is processed; the update is ignored.
  - In ARMED the previously staged time is loaded.
  - An internal holdover tick coinciding with PPS counts as one increment only.
- Reset mid-operation returns every register to its reset value immediately, regardless of state.

Decomposition:
- Shared package gps_clock_pkg:
  - sync_state encodings ACQUIRE/ARMED/LOCKED/HOLDOVER.
  - Digit limits (9, 5, 23).
  - BCD time struct/width constants, reused by the capture and display blocks.
- One combinational sub-module, bcd_time_inc: 6 BCD digits in → digits+1s out with 23:59:59 wrap. It is used for the staged+1 load and for all increments.

Test Plan:
- Bench uses CLK_HZ=100, PPS_MARGIN=10. Reset, update 12:34:56, PPS at cycle 20 → ARMED after update; digits 12:34:57 and sec_tick the cycle after PPS; state LOCKED; time_valid=1.
- LOCKED at 23:59:59, PPS → 00:00:00. At 09:59:59, PPS → 10:00:00.
- LOCKED, PPS stops → at 110 cycles HOLDOVER, +1s. Then +1s every 100 cycles. After a late PPS at cyc_cnt=60 → +1s, state LOCKED.
- HOLDOVER_MAX_S=3, no PPS → three holdover ticks, then ACQUIRE with time_valid=0 and digits frozen.
- LOCKED showing 01:00:00, two updates 05:00:00 → ARMED after the second. Next PPS → 05:00:01.
- Update 12:60:00 (min_2=6) in ACQUIRE → ignored, state stays ACQUIRE. Update coincident with PPS in LOCKED → mismatch_cnt unchanged.
